// File: rtl/ahb_bus_arbiter.sv
// Round-robin arbiter that shares one AHB master port between several requesters.
// Each owner may hold the bus for at most MAX_HOLD beats unless it asserts Bus_Lock.
module ahb_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_HOLD       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         bus_req_i,
  input  logic [NUM_MASTERS-1:0]         bus_lock_i,
  input  logic [1:0]                     htrans_i,
  input  logic                           hready_i,
  output logic [NUM_MASTERS-1:0]         bus_grant_o,
  output logic [$clog2(NUM_MASTERS)-1:0] hmaster_o,
  output logic [$clog2(NUM_MASTERS)-1:0] hmaster_data_o,
  output logic                           arb_owned_o
);

  localparam int unsigned MW = $clog2(NUM_MASTERS);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0]    HtransSeq = 2'b11;
  localparam logic [MW-1:0] DefIdx    = MW'(DEFAULT_MASTER);
  localparam logic [MW-1:0] LastIdx   = MW'(NUM_MASTERS - 1);
  localparam logic [HW-1:0] HoldMax   = HW'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic [MW-1:0]          hdata_q, hdata_d;
  logic [MW-1:0]          last_q, last_d;
  logic [HW-1:0]          hold_q, hold_d;

  logic [NUM_MASTERS-1:0] owner_oh;
  logic [NUM_MASTERS-1:0] scan_req;
  logic                   owner_drop;
  logic                   others_req;
  logic                   preempt;
  logic                   arb_point;
  logic                   found;
  logic [MW-1:0]          sel;
  logic [MW-1:0]          cand;

  // While owned, hmaster_q is the owner index.
  assign owner_oh   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << hmaster_q;
  assign owner_drop = ~bus_req_i[hmaster_q];
  assign others_req = |(bus_req_i & ~owner_oh);
  assign preempt    = (hold_q >= HoldMax) && ~bus_lock_i[hmaster_q] &&
                      (htrans_i != HtransSeq) && others_req;

  // The current owner never wins a re-arbitration; from idle everyone competes.
  assign scan_req = (state_q == StOwned) ? (bus_req_i & ~owner_oh) : bus_req_i;

  // Round-robin scan starting just after the last owner.
  always_comb begin
    found = 1'b0;
    sel   = DefIdx;
    cand  = last_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (cand == LastIdx) ? '0 : cand + 1'b1;
      if (!found && scan_req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    hmaster_d = hmaster_q;
    last_d    = last_q;
    hold_d    = hold_q;
    arb_point = 1'b0;
    hdata_d   = hready_i ? hmaster_q : hdata_q;

    unique case (state_q)
      StIdle: begin
        arb_point = 1'b1;
      end
      StOwned: begin
        arb_point = hready_i && (owner_drop || preempt);
        if (!arb_point && hready_i && htrans_i[1] && (hold_q < HoldMax)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        arb_point = 1'b1;
      end
    endcase

    if (arb_point) begin
      hold_d = '0;
      if (found) begin
        state_d   = StOwned;
        grant_d   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << sel;
        hmaster_d = sel;
        last_d    = sel;
      end else begin
        state_d   = StIdle;
        grant_d   = '0;
        hmaster_d = DefIdx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      hmaster_q <= DefIdx;
      hdata_q   <= DefIdx;
      last_q    <= LastIdx;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      hmaster_q <= hmaster_d;
      hdata_q   <= hdata_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
    end
  end

  assign bus_grant_o    = grant_q;
  assign hmaster_o      = hmaster_q;
  assign hmaster_data_o = hdata_q;
  assign arb_owned_o    = (state_q == StOwned);

endmodule
